shift_right_unit: RTL

Multi-cycle right shifter for the MIPS datapath, the complement of the existing combinational left shifter. It executes SRL/SRA/SRLV/SRAV by shifting an operand right by up to STEP bits per clock under a start/done handshake. It sits beside the ALU and is driven by the control unit, which stalls on `busy`. The iterative structure avoids a full 32-bit right barrel shifter.

---
 rtl/shift_right_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/shift_right_unit.sv
// shift_right_unit: iterative right shifter for SRL/SRA/SRLV/SRAV.
// Shifts the captured operand right by up to STEP bits per clock and
// reports completion through a start/busy/done handshake.
module shift_right_unit #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [5:0]  shiftAmmount,
    input  logic        arith,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [5:0]  rem_q, rem_d;
    logic        fill_q, fill_d;
    logic [31:0] out_q, out_d;

    logic [5:0]  step_amt;
    logic [5:0]  amt_sat;
    logic [31:0] shifted;

    // Right shift by s with the vacated MSBs forced to the fill bit.
    function automatic logic [31:0] shr_fill(input logic [31:0] a,
                                             input logic [5:0]  s,
                                             input logic        f);
        logic [31:0] ones;
        ones = '1;
        return (a >> s) | ({32{f}} & ~(ones >> s));
    endfunction

    // Next-state, datapath and result computation.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        out_d    = out_q;
        // Amounts beyond 32 give the same result as 32: every bit is fill.
        amt_sat  = (shiftAmmount > 6'd32) ? 6'd32 : shiftAmmount;
        step_amt = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        shifted  = shr_fill(acc_q, step_amt, fill_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d  = in;
                    rem_d  = amt_sat;
                    fill_d = arith & in[31];
                    if (amt_sat == 6'd0) begin
                        out_d   = in;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // start is deliberately ignored here; requests are not queued.
                acc_d = shifted;
                rem_d = rem_q - step_amt;
                if (rem_d == 6'd0) begin
                    out_d   = shifted;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

endmodule
